// File: rtl/mem_access_arbiter_pkg.sv
// Shared configuration for the IFU/LSU memory access sequencer: default widths,
// FSM state and owner encodings, and the fixed instruction fetch length.
package mem_access_arbiter_pkg;

    localparam int ADDR_W_DEF    = 64;
    localparam int DATA_W_DEF    = 64;
    localparam int INST_W_DEF    = 32;
    localparam int LEN_W_DEF     = 8;
    localparam int IFU_LEN_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_LSU = 1'b0,
        OWN_IFU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_access_arbiter_rr.sv
// Two-way round-robin arbiter between LSU and IFU; the last-grant pointer only
// moves when a grant is actually issued (gnt_en high).
module mem_rr_arb2
    import mem_access_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic gnt_en,
    input  logic req_lsu,
    input  logic req_ifu,
    output logic gnt_lsu,
    output logic gnt_ifu
);

    owner_e last_q;
    owner_e last_d;

    // Grant selection: on contention favour whoever was not served last
    always_comb begin
        gnt_lsu = 1'b0;
        gnt_ifu = 1'b0;
        last_d  = last_q;
        if (gnt_en) begin
            if (req_lsu && req_ifu) begin
                if (last_q == OWN_IFU) begin
                    gnt_lsu = 1'b1;
                end else begin
                    gnt_ifu = 1'b1;
                end
            end else if (req_lsu) begin
                gnt_lsu = 1'b1;
            end else if (req_ifu) begin
                gnt_ifu = 1'b1;
            end else begin
                gnt_lsu = 1'b0;
            end
        end else begin
            gnt_lsu = 1'b0;
        end
        if (gnt_lsu) begin
            last_d = OWN_LSU;
        end else if (gnt_ifu) begin
            last_d = OWN_IFU;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant pointer; after reset the LSU wins the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= OWN_IFU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Sequencer sharing one single-port memory between IFU and LSU: one transaction
// at a time, round-robin grant, response timeout, registered response routing.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INST_W  = INST_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = 256
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iIfuReqValid,
    output logic              oIfuReqReady,
    input  logic [ADDR_W-1:0] iIfuAddr,
    output logic              oIfuRespValid,
    input  logic              iIfuRespReady,
    output logic [INST_W-1:0] oIfuRespData,
    output logic              oIfuRespErr,
    input  logic              iLsuReqValid,
    output logic              oLsuReqReady,
    input  logic [ADDR_W-1:0] iLsuAddr,
    input  logic              iLsuWen,
    input  logic [DATA_W-1:0] iLsuWrData,
    input  logic [LEN_W-1:0]  iLsuLen,
    output logic              oLsuRespValid,
    input  logic              iLsuRespReady,
    output logic [DATA_W-1:0] oLsuRespData,
    output logic              oLsuRespErr,
    output logic              oMemReqValid,
    input  logic              iMemReqReady,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemWen,
    output logic [DATA_W-1:0] oMemWrData,
    output logic [LEN_W-1:0]  oMemLen,
    input  logic              iMemRespValid,
    input  logic [DATA_W-1:0] iMemRespData
);

    localparam int               CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LEN_W-1:0]  mem_len_q, mem_len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              ifu_resp_valid_q, ifu_resp_valid_d;
    logic              lsu_resp_valid_q, lsu_resp_valid_d;
    logic              ifu_err_q, ifu_err_d;
    logic              lsu_err_q, lsu_err_d;

    logic gnt_en_s;
    logic gnt_lsu_s;
    logic gnt_ifu_s;

    assign gnt_en_s = iReset && (state_q == ST_IDLE);

    mem_rr_arb2 u_arb (
        .clk     (iClock),
        .rst_n   (iReset),
        .gnt_en  (gnt_en_s),
        .req_lsu (iLsuReqValid),
        .req_ifu (iIfuReqValid),
        .gnt_lsu (gnt_lsu_s),
        .gnt_ifu (gnt_ifu_s)
    );

    // Next-state and datapath capture for the IDLE/REQ/WAIT/RESP sequence
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        mem_req_valid_d  = mem_req_valid_q;
        mem_addr_d       = mem_addr_q;
        mem_wen_d        = mem_wen_q;
        mem_wdata_d      = mem_wdata_q;
        mem_len_d        = mem_len_q;
        cnt_d            = cnt_q;
        resp_data_d      = resp_data_q;
        ifu_resp_valid_d = ifu_resp_valid_q;
        lsu_resp_valid_d = lsu_resp_valid_q;
        ifu_err_d        = ifu_err_q;
        lsu_err_d        = lsu_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_lsu_s) begin
                    owner_d         = OWN_LSU;
                    mem_addr_d      = iLsuAddr;
                    mem_wen_d       = iLsuWen;
                    mem_wdata_d     = iLsuWrData;
                    mem_len_d       = iLsuLen;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_REQ;
                end else if (gnt_ifu_s) begin
                    owner_d         = OWN_IFU;
                    mem_addr_d      = iIfuAddr;
                    mem_wen_d       = 1'b0;
                    mem_wdata_d     = {DATA_W{1'b0}};
                    mem_len_d       = LEN_W'(IFU_LEN_BYTES);
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (iMemReqReady) begin
                    mem_req_valid_d = 1'b0;
                    cnt_d           = {CNT_W{1'b0}};
                    state_d         = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A response arriving on the last counted cycle still wins
                if (iMemRespValid) begin
                    resp_data_d      = mem_wen_q ? {DATA_W{1'b0}} : iMemRespData;
                    ifu_err_d        = 1'b0;
                    lsu_err_d        = 1'b0;
                    ifu_resp_valid_d = (owner_q == OWN_IFU);
                    lsu_resp_valid_d = (owner_q == OWN_LSU);
                    state_d          = ST_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    resp_data_d      = {DATA_W{1'b0}};
                    ifu_err_d        = (owner_q == OWN_IFU);
                    lsu_err_d        = (owner_q == OWN_LSU);
                    ifu_resp_valid_d = (owner_q == OWN_IFU);
                    lsu_resp_valid_d = (owner_q == OWN_LSU);
                    state_d          = ST_RESP;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                if ((owner_q == OWN_IFU) ? iIfuRespReady : iLsuRespReady) begin
                    ifu_resp_valid_d = 1'b0;
                    lsu_resp_valid_d = 1'b0;
                    ifu_err_d        = 1'b0;
                    lsu_err_d        = 1'b0;
                    state_d          = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q          <= ST_IDLE;
            owner_q          <= OWN_IFU;
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= {ADDR_W{1'b0}};
            mem_wen_q        <= 1'b0;
            mem_wdata_q      <= {DATA_W{1'b0}};
            mem_len_q        <= {LEN_W{1'b0}};
            cnt_q            <= {CNT_W{1'b0}};
            resp_data_q      <= {DATA_W{1'b0}};
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_err_q        <= 1'b0;
            lsu_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_addr_q       <= mem_addr_d;
            mem_wen_q        <= mem_wen_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_len_q        <= mem_len_d;
            cnt_q            <= cnt_d;
            resp_data_q      <= resp_data_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            ifu_err_q        <= ifu_err_d;
            lsu_err_q        <= lsu_err_d;
        end
    end

    assign oIfuReqReady  = gnt_ifu_s;
    assign oLsuReqReady  = gnt_lsu_s;
    assign oMemReqValid  = mem_req_valid_q;
    assign oMemAddr      = mem_addr_q;
    assign oMemWen       = mem_wen_q;
    assign oMemWrData    = mem_wdata_q;
    assign oMemLen       = mem_len_q;
    assign oIfuRespValid = ifu_resp_valid_q;
    assign oIfuRespData  = resp_data_q[INST_W-1:0];
    assign oIfuRespErr   = ifu_err_q;
    assign oLsuRespValid = lsu_resp_valid_q;
    assign oLsuRespData  = resp_data_q;
    assign oLsuRespErr   = lsu_err_q;

endmodule
